// File: rtl/xy_scan_sequencer_if.sv
// Bus bundle between the host/pace-controller side and the XY scan sequencer.
// Handshake: every *_val strobe and scan_done is a one-cycle pulse qualified
// by nothing else; there is no ready. The receiver must accept the data in
// the strobe cycle. done_x/done_y are one-cycle pulses back from the pace
// controllers and are only honoured while the sequencer waits for them.
interface xy_scan_sequencer_if;
    logic        start;
    logic        abort;
    logic [15:0] cfg_x_start;
    logic [15:0] cfg_x_end;
    logic [15:0] cfg_y_start;
    logic [15:0] cfg_y_pitch;
    logic [15:0] cfg_lines;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic [15:0] em_new_x;
    logic [15:0] em_new_y;
    logic        em_new_val_x;
    logic        em_new_val_y;
    logic [15:0] bc_new;
    logic        bc_new_val;
    logic        done_x;
    logic        done_y;
    logic        busy;
    logic        laser_en;
    logic [15:0] line_idx;
    logic        scan_done;
    logic        err;
    logic [3:0]  dbg_state;

    // Host / pace-controller side.
    modport master (
        output start, abort, cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_pitch,
               cfg_lines, cfg_step, cfg_dwell, done_x, done_y,
        input  em_new_x, em_new_y, em_new_val_x, em_new_val_y, bc_new,
               bc_new_val, busy, laser_en, line_idx, scan_done, err, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_x_start, cfg_x_end, cfg_y_start, cfg_y_pitch,
               cfg_lines, cfg_step, cfg_dwell, done_x, done_y,
        output em_new_x, em_new_y, em_new_val_x, em_new_val_y, bc_new,
               bc_new_val, busy, laser_en, line_idx, scan_done, err, dbg_state
    );
endinterface

// File: rtl/xy_scan_sequencer.sv
// Serpentine raster-scan scheduler driving one pace controller per galvo axis.
// Loads the step size, homes both axes, then alternates X sweeps (laser on),
// dwell and one-pitch Y steps until the programmed line count is done.
// A watchdog bounds every wait for a done pulse.
module xy_scan_sequencer #(
    parameter logic [23:0] TIMEOUT = 24'd4_000_000,
    parameter int          GAP     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    xy_scan_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_GAP1   = 4'd2,
        S_HOME   = 4'd3,
        S_WAIT_H = 4'd4,
        S_GAP_L  = 4'd5,
        S_LINE   = 4'd6,
        S_WAIT_L = 4'd7,
        S_DWELL  = 4'd8,
        S_STEP_Y = 4'd9,
        S_WAIT_Y = 4'd10,
        S_DONE   = 4'd11
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP - 1);
    localparam logic [23:0] WD_LAST  = TIMEOUT - 24'd1;

    state_t      state;
    logic [15:0] x_start_r, x_end_r, pitch_r, lines_r, dwell_r;
    logic [15:0] ycur;
    logic        dir;
    logic [7:0]  gcnt;
    logic [15:0] dcnt;
    logic [23:0] wd;
    logic        flag_x, flag_y;

    logic [15:0] em_new_x_r, em_new_y_r, bc_new_r, line_idx_r;
    logic        em_new_val_x_r, em_new_val_y_r, bc_new_val_r;
    logic        busy_r, laser_en_r, scan_done_r, err_r;

    // Home completion uses the sticky flags plus this cycle's pulses so that
    // simultaneous done_x/done_y complete in one cycle.
    logic home_x, home_y;
    assign home_x = flag_x | bus.done_x;
    assign home_y = flag_y | bus.done_y;

    // Scan sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            x_start_r      <= '0;
            x_end_r        <= '0;
            pitch_r        <= '0;
            lines_r        <= '0;
            dwell_r        <= '0;
            ycur           <= '0;
            dir            <= 1'b0;
            gcnt           <= '0;
            dcnt           <= '0;
            wd             <= '0;
            flag_x         <= 1'b0;
            flag_y         <= 1'b0;
            em_new_x_r     <= '0;
            em_new_y_r     <= '0;
            bc_new_r       <= '0;
            line_idx_r     <= '0;
            em_new_val_x_r <= 1'b0;
            em_new_val_y_r <= 1'b0;
            bc_new_val_r   <= 1'b0;
            busy_r         <= 1'b0;
            laser_en_r     <= 1'b0;
            scan_done_r    <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            em_new_val_x_r <= 1'b0;
            em_new_val_y_r <= 1'b0;
            bc_new_val_r   <= 1'b0;
            scan_done_r    <= 1'b0;
            if (bus.abort) begin
                // Abort wins over start and done; err and line_idx are kept.
                state      <= S_IDLE;
                busy_r     <= 1'b0;
                laser_en_r <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            x_start_r    <= bus.cfg_x_start;
                            x_end_r      <= bus.cfg_x_end;
                            pitch_r      <= bus.cfg_y_pitch;
                            lines_r      <= bus.cfg_lines;
                            dwell_r      <= bus.cfg_dwell;
                            ycur         <= bus.cfg_y_start;
                            dir          <= 1'b0;
                            err_r        <= 1'b0;
                            line_idx_r   <= '0;
                            busy_r       <= 1'b1;
                            bc_new_r     <= bus.cfg_step;
                            bc_new_val_r <= 1'b1;
                            state        <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        gcnt  <= '0;
                        state <= S_GAP1;
                    end
                    S_GAP1: begin
                        // Controllers ignore targets right after a step-size load.
                        if (gcnt == GAP_LAST) begin
                            em_new_x_r     <= x_start_r;
                            em_new_y_r     <= ycur;
                            em_new_val_x_r <= 1'b1;
                            em_new_val_y_r <= 1'b1;
                            state          <= S_HOME;
                        end else begin
                            gcnt <= gcnt + 8'd1;
                        end
                    end
                    S_HOME: begin
                        flag_x <= 1'b0;
                        flag_y <= 1'b0;
                        wd     <= '0;
                        state  <= S_WAIT_H;
                    end
                    S_WAIT_H: begin
                        flag_x <= home_x;
                        flag_y <= home_y;
                        if (home_x && home_y) begin
                            if (lines_r == 16'd0) begin
                                scan_done_r <= 1'b1;
                                busy_r      <= 1'b0;
                                state       <= S_DONE;
                            end else begin
                                gcnt  <= '0;
                                state <= S_GAP_L;
                            end
                        end else if (wd == WD_LAST) begin
                            err_r      <= 1'b1;
                            laser_en_r <= 1'b0;
                            busy_r     <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            wd <= wd + 24'd1;
                        end
                    end
                    S_GAP_L: begin
                        // Gap before every sweep strobe, after home or Y step.
                        if (gcnt == GAP_LAST) begin
                            em_new_x_r     <= dir ? x_start_r : x_end_r;
                            em_new_val_x_r <= 1'b1;
                            laser_en_r     <= 1'b1;
                            state          <= S_LINE;
                        end else begin
                            gcnt <= gcnt + 8'd1;
                        end
                    end
                    S_LINE: begin
                        wd    <= '0;
                        state <= S_WAIT_L;
                    end
                    S_WAIT_L: begin
                        if (bus.done_x) begin
                            laser_en_r <= 1'b0;
                            // line_idx stays on the last line when the scan ends.
                            if ((line_idx_r + 16'd1) == lines_r) begin
                                scan_done_r <= 1'b1;
                                busy_r      <= 1'b0;
                                state       <= S_DONE;
                            end else begin
                                line_idx_r <= line_idx_r + 16'd1;
                                dcnt       <= '0;
                                state      <= S_DWELL;
                            end
                        end else if (wd == WD_LAST) begin
                            err_r      <= 1'b1;
                            laser_en_r <= 1'b0;
                            busy_r     <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            wd <= wd + 24'd1;
                        end
                    end
                    S_DWELL: begin
                        // Dwell of 0 still spends one cycle here.
                        if (({1'b0, dcnt} + 17'd1) >= {1'b0, dwell_r}) begin
                            ycur           <= ycur + pitch_r;
                            em_new_y_r     <= ycur + pitch_r;
                            em_new_val_y_r <= 1'b1;
                            dir            <= ~dir;
                            state          <= S_STEP_Y;
                        end else begin
                            dcnt <= dcnt + 16'd1;
                        end
                    end
                    S_STEP_Y: begin
                        wd    <= '0;
                        state <= S_WAIT_Y;
                    end
                    S_WAIT_Y: begin
                        if (bus.done_y) begin
                            gcnt  <= '0;
                            state <= S_GAP_L;
                        end else if (wd == WD_LAST) begin
                            err_r      <= 1'b1;
                            laser_en_r <= 1'b0;
                            busy_r     <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            wd <= wd + 24'd1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.em_new_x     = em_new_x_r;
    assign bus.em_new_y     = em_new_y_r;
    assign bus.em_new_val_x = em_new_val_x_r;
    assign bus.em_new_val_y = em_new_val_y_r;
    assign bus.bc_new       = bc_new_r;
    assign bus.bc_new_val   = bc_new_val_r;
    assign bus.busy         = busy_r;
    assign bus.laser_en     = laser_en_r;
    assign bus.line_idx     = line_idx_r;
    assign bus.scan_done    = scan_done_r;
    assign bus.err          = err_r;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_xy_scan_sequencer.sv
// Bench for xy_scan_sequencer: pace-controller responder, event-list model of
// a serpentine scan, directed and randomized scans, timeout and abort cases.
module tb_xy_scan_sequencer;
    localparam int          GAP     = 2;
    localparam logic [23:0] TIMEOUT = 24'd1000;

    localparam logic [3:0] K_BC   = 4'd1;
    localparam logic [3:0] K_HOME = 4'd2;
    localparam logic [3:0] K_LINE = 4'd3;
    localparam logic [3:0] K_Y    = 4'd4;
    localparam logic [3:0] K_DONE = 4'd5;

    // Clock / reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xy_scan_sequencer_if bus ();

    xy_scan_sequencer #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expected events: {kind, x, y, delay from triggering event}.
    logic [51:0] exp_q[$];

    int cyc           = 0;
    int trig_cyc      = 0;
    int cx            = 0;
    int cy            = 0;
    bit cx_line       = 1'b0;
    int lat_lo        = 50;
    int lat_hi        = 50;
    bit hold_line_x   = 1'b0;
    int sd_cnt        = 0;
    int strobe_cnt    = 0;
    bit laser_seen    = 1'b0;
    int line_cyc      = 0;
    int line_done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic [3:0] k, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] dly);
        exp_q.push_back({k, x, y, dly});
    endtask

    // Reference model: the list of strobes a complete scan must produce.
    task automatic build_model(input logic [15:0] xs, input logic [15:0] xe, input logic [15:0] ys,
                               input logic [15:0] pitch, input logic [15:0] lines,
                               input logic [15:0] stp, input logic [15:0] dwell);
        logic [15:0] y;
        int          dw;
        y  = ys;
        dw = (dwell == 16'd0) ? 1 : int'(dwell);
        push_ev(K_BC, stp, 16'd0, 16'd1);
        push_ev(K_HOME, xs, ys, 16'(GAP + 2));
        for (int i = 0; i < int'(lines); i++) begin
            if (i > 0) begin
                y = y + pitch;
                push_ev(K_Y, 16'd0, y, 16'(dw + 1));
            end
            push_ev(K_LINE, (i % 2 == 0) ? xe : xs, 16'd0, 16'(GAP + 1));
        end
        push_ev(K_DONE, 16'd0, (lines == 16'd0) ? 16'd0 : lines - 16'd1, 16'd1);
    endtask

    task automatic observe(input logic [3:0] k, input logic [15:0] x, input logic [15:0] y);
        logic [51:0] e;
        if (exp_q.size() == 0) begin
            check("extra_event_kind", {28'd0, k}, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", {28'd0, k}, {28'd0, e[51:48]});
            check("event_x", {16'd0, x}, {16'd0, e[47:32]});
            check("event_y", {16'd0, y}, {16'd0, e[31:16]});
            check("event_delay", cyc - trig_cyc, {16'd0, e[15:0]});
        end
    endtask

    // Monitor and pace-controller responder, on the falling edge.
    initial begin
        bus.done_x = 1'b0;
        bus.done_y = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.laser_en) laser_seen = 1'b1;
                if (bus.bc_new_val || bus.em_new_val_x || bus.em_new_val_y) strobe_cnt++;
                if (bus.bc_new_val) begin
                    observe(K_BC, bus.bc_new, 16'd0);
                    check("busy_at_load", {31'd0, bus.busy}, 32'd1);
                end
                if (bus.em_new_val_x && bus.em_new_val_y) begin
                    observe(K_HOME, bus.em_new_x, bus.em_new_y);
                end else if (bus.em_new_val_x) begin
                    observe(K_LINE, bus.em_new_x, 16'd0);
                    check("laser_on_sweep", {31'd0, bus.laser_en}, 32'd1);
                    line_cyc = cyc;
                end else if (bus.em_new_val_y) begin
                    observe(K_Y, 16'd0, bus.em_new_y);
                    check("laser_off_ystep", {31'd0, bus.laser_en}, 32'd0);
                end
                if (bus.scan_done) begin
                    observe(K_DONE, 16'd0, bus.line_idx);
                    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
                    check("laser_at_done", {31'd0, bus.laser_en}, 32'd0);
                    sd_cnt++;
                end
            end
            bus.done_x = 1'b0;
            bus.done_y = 1'b0;
            if (cx > 0) begin
                cx--;
                if (cx == 0) begin
                    bus.done_x = 1'b1;
                    trig_cyc   = cyc;
                    if (cx_line) line_done_cnt++;
                end
            end
            if (cy > 0) begin
                cy--;
                if (cy == 0) begin
                    bus.done_y = 1'b1;
                    trig_cyc   = cyc;
                end
            end
            if (!rst && bus.em_new_val_x && !(hold_line_x && !bus.em_new_val_y)) begin
                cx      = int'($urandom_range(lat_hi, lat_lo));
                cx_line = !bus.em_new_val_y;
            end
            if (!rst && bus.em_new_val_y) cy = int'($urandom_range(lat_hi, lat_lo));
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] xs, input logic [15:0] xe, input logic [15:0] ys,
                           input logic [15:0] pitch, input logic [15:0] lines,
                           input logic [15:0] stp, input logic [15:0] dwell);
        bus.cfg_x_start = xs;
        bus.cfg_x_end   = xe;
        bus.cfg_y_start = ys;
        bus.cfg_y_pitch = pitch;
        bus.cfg_lines   = lines;
        bus.cfg_step    = stp;
        bus.cfg_dwell   = dwell;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        trig_cyc  = cyc + 1;
        step_cyc();
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        check("err_clear_on_start", {31'd0, bus.err}, 32'd0);
    endtask

    task automatic run_scan(input logic [15:0] xs, input logic [15:0] xe, input logic [15:0] ys,
                            input logic [15:0] pitch, input logic [15:0] lines,
                            input logic [15:0] stp, input logic [15:0] dwell,
                            input int lo, input int hi, input bit poke_busy);
        int sd0;
        lat_lo = lo;
        lat_hi = hi;
        set_cfg(xs, xe, ys, pitch, lines, stp, dwell);
        build_model(xs, xe, ys, pitch, lines, stp, dwell);
        sd0 = sd_cnt;
        pulse_start();
        if (poke_busy) begin
            repeat (20) step_cyc();
            set_cfg(16'd7, 16'd77, 16'd777, 16'd1, 16'd9, 16'd45, 16'd0);
            bus.start = 1'b1;
            step_cyc();
            bus.start = 1'b0;
        end
        for (int i = 0; i < 5000 && sd_cnt == sd0 && !bus.err; i++) step_cyc();
        check("scan_done_count", sd_cnt - sd0, 32'd1);
        check("model_events_left", exp_q.size(), 32'd0);
        check("err_after_scan", {31'd0, bus.err}, 32'd0);
        check("busy_after_scan", {31'd0, bus.busy}, 32'd0);
        exp_q.delete();
        repeat (4) step_cyc();
    endtask

    initial begin
        int s0;
        int sd0;
        int ld0;
        logic [15:0] rl;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

        // Reset values.
        rst = 1'b1;
        repeat (5) step_cyc();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_laser", {31'd0, bus.laser_en}, 32'd0);
        check("rst_bc_val", {31'd0, bus.bc_new_val}, 32'd0);
        check("rst_val_x", {31'd0, bus.em_new_val_x}, 32'd0);
        check("rst_val_y", {31'd0, bus.em_new_val_y}, 32'd0);
        check("rst_scan_done", {31'd0, bus.scan_done}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_line_idx", {16'd0, bus.line_idx}, 32'd0);
        check("rst_em_x", {16'd0, bus.em_new_x}, 32'd0);
        check("rst_em_y", {16'd0, bus.em_new_y}, 32'd0);
        check("rst_bc_new", {16'd0, bus.bc_new}, 32'd0);
        rst = 1'b0;
        step_cyc();

        // Basic scan, simultaneous home dones, start ignored while busy.
        run_scan(16'd1000, 16'd9000, 16'd500, 16'd200, 16'd3, 16'd30, 16'd10, 50, 50, 1'b1);
        check("basic_line_idx", {16'd0, bus.line_idx}, 32'd2);

        // Zero lines: laser never rises.
        laser_seen = 1'b0;
        run_scan(16'd100, 16'd200, 16'd300, 16'd5, 16'd0, 16'd20, 16'd3, 1, 30, 1'b0);
        check("zero_lines_laser", {31'd0, laser_seen}, 32'd0);

        // Y wrap.
        run_scan(16'd10, 16'd20, 16'hFF00, 16'h0200, 16'd2, 16'd15, 16'd0, 1, 10, 1'b0);

        // Randomized scans.
        for (int n = 0; n < 6; n++) begin
            rl = 16'($urandom_range(4, 0));
            run_scan(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), rl,
                     16'($urandom_range(45, 15)), 16'($urandom_range(20, 0)), 1, 20, 1'b0);
        end

        // Timeout in line 0.
        hold_line_x = 1'b1;
        lat_lo = 5;
        lat_hi = 5;
        set_cfg(16'd1000, 16'd9000, 16'd500, 16'd200, 16'd2, 16'd30, 16'd10);
        push_ev(K_BC, 16'd30, 16'd0, 16'd1);
        push_ev(K_HOME, 16'd1000, 16'd500, 16'(GAP + 2));
        push_ev(K_LINE, 16'd9000, 16'd0, 16'(GAP + 1));
        sd0 = sd_cnt;
        pulse_start();
        for (int i = 0; i < 3000 && !bus.err; i++) step_cyc();
        check("timeout_err", {31'd0, bus.err}, 32'd1);
        check("timeout_cycles", (cyc + 1) - line_cyc, 32'(TIMEOUT) + 32'd1);
        check("timeout_busy", {31'd0, bus.busy}, 32'd0);
        check("timeout_laser", {31'd0, bus.laser_en}, 32'd0);
        check("timeout_no_done", sd_cnt - sd0, 32'd0);
        check("timeout_events_left", exp_q.size(), 32'd0);
        exp_q.delete();
        hold_line_x = 1'b0;
        repeat (10) step_cyc();
        // A following start clears err and scans normally.
        run_scan(16'd50, 16'd60, 16'd70, 16'd80, 16'd1, 16'd25, 16'd2, 1, 8, 1'b0);

        // Abort during the dwell after line 0.
        lat_lo = 5;
        lat_hi = 5;
        set_cfg(16'd1000, 16'd9000, 16'd500, 16'd200, 16'd3, 16'd30, 16'd40);
        build_model(16'd1000, 16'd9000, 16'd500, 16'd200, 16'd3, 16'd30, 16'd40);
        ld0 = line_done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && line_done_cnt == ld0; i++) step_cyc();
        repeat (5) step_cyc();
        bus.abort = 1'b1;
        step_cyc();
        bus.abort = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_line_idx", {16'd0, bus.line_idx}, 32'd1);
        check("abort_laser", {31'd0, bus.laser_en}, 32'd0);
        check("abort_err_held", {31'd0, bus.err}, 32'd0);
        exp_q.delete();
        s0 = strobe_cnt;
        repeat (100) step_cyc();
        check("abort_no_strobes", strobe_cnt - s0, 32'd0);

        // Start and abort in the same cycle.
        s0 = strobe_cnt;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step_cyc();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", {31'd0, bus.busy}, 32'd0);
        check("start_abort_bc_val", {31'd0, bus.bc_new_val}, 32'd0);
        repeat (8) step_cyc();
        check("start_abort_idle", {31'd0, bus.busy}, 32'd0);
        check("start_abort_strobes", strobe_cnt - s0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xy_scan_sequencer.md
# xy_scan_sequencer

Raster-scan scheduler for the galvo path. It drives two electrical-machine pace controllers, one per axis, and sequences a serpentine scan across them. For each scan it loads the step size, homes both axes, sweeps X with the laser gated on, dwells, then steps Y by one pitch, until the programmed line count is reached. It sits between the host configuration registers and the per-axis pace controllers that feed the XY2-100 transmitters.

## Interface
- TIMEOUT, 24'd4_000_000: cycles allowed for any wait-for-done (100 ms at 40 MHz).
- GAP, 2: idle cycles inserted after a done, or after a step-size load, before the next target pulse (min 2).
- clk  in  1  system clock, 40 MHz. One clock domain.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  single-cycle pulse. Latches all cfg_* inputs and begins a scan. Ignored while busy=1.
- abort  in  1  single-cycle pulse. Returns the block to IDLE from any state.
- cfg_x_start, cfg_x_end  in  16  X sweep endpoints.
- cfg_y_start, cfg_y_pitch  in  16  first Y position and per-line Y increment.
- cfg_lines  in  16  number of X sweeps.
- cfg_step  in  16  per-frame step size, 15..45.
- cfg_dwell  in  16  dwell cycles between lines.
- em_new_x, em_new_y  out  16  target positions to the pace controllers.
- em_new_val_x, em_new_val_y  out  1  target strobes, one cycle each.
- bc_new  out  16  step size, shared by both controllers.
- bc_new_val  out  1  step-size strobe to both controllers, one cycle.
- done_x, done_y  in  1  send_done pulses from the pace controllers.
- busy  out  1  high from the cycle after start until return to IDLE.
- laser_en  out  1  laser gate; high only during a line sweep.
- line_idx  out  16  index of the current or last line, 0-based.
- scan_done  out  1  one-cycle pulse when all lines are complete.
- err  out  1  sticky timeout flag. Cleared by rst or by an accepted start.

## Operation
- All outputs are registered. After reset every output is 0 and the state is IDLE.
- IDLE: on start, latch the cfg values, clear err and line_idx, set ycur=cfg_y_start and dir=0, then go to LOAD.
- LOAD: assert bc_new=step and bc_new_val for one cycle, then go to GAP1.
- GAP1: wait GAP cycles. The pace controller needs 2 cycles to get back to idle after the step-size load; it ignores a target pulse during that window.
- HOME: assert em_new_x=x_start, em_new_y=ycur, and both val strobes in the same cycle. Go to WAIT_H.
- WAIT_H: set sticky flags on done_x and done_y. When both flags are set:
  - go to DONE if lines==0;
  - otherwise wait GAP cycles, then go to LINE.
- LINE: assert em_new_x = (dir ? x_start : x_end) with em_new_val_x, and set laser_en=1. Go to WAIT_L.
- WAIT_L: on done_x, clear laser_en in the following cycle and increment line_idx (16-bit). If line_idx+1==lines go to DONE, else go to DWELL.
- DWELL: count cfg_dwell cycles. A value of 0 passes through in 1 cycle. Then go to STEP_Y.
- STEP_Y:
  - ycur <= ycur + pitch, modulo 2^16. There is no saturation; configuration must keep the scan in range.
  - Assert em_new_y with the new ycur and em_new_val_y, toggle dir, then go to WAIT_Y.
- WAIT_Y: on done_y, wait GAP cycles, then go to LINE.
- DONE: pulse scan_done for 1 cycle and go to IDLE. busy drops in the same cycle scan_done is high.
- Watchdog:
  - The counter is cleared on entry to WAIT_H, WAIT_L and WAIT_Y, and counts while in those states.
  - When it reaches TIMEOUT-1 with no required done, set err=1, clear laser_en, and go to IDLE with no scan_done.
- Targets equal to the current position are still issued. The pace controller completes them on its next frame and returns done.
- A done pulse arriving outside a wait state is ignored.

## Timing
- start sampled at cycle T:
  - busy=1 and bc_new_val=1 at T+1;
  - GAP cycles follow;
  - HOME strobes at T+2+GAP, which is T+4 with GAP=2.
- A strobe is never issued earlier than GAP+1 cycles after the done that enabled it.
- laser_en rises in the same cycle as em_new_val_x of a LINE. It falls the cycle after done_x is sampled.
- done_x and done_y in the same cycle of WAIT_H: both flags are set and the wait completes.
- abort has priority over every other event, including start and done in the same cycle. On the next edge:
  - the state is IDLE;
  - busy, laser_en and all strobes are 0;
  - err and line_idx are held.
- rst mid-scan behaves as abort, and additionally clears err and line_idx.
- start while busy: no effect, and no cfg re-latch.

## Test plan
- Basic scan: x 1000->9000, y_start=500, pitch=200, lines=3, step=30, dwell=10, with done pulses returned 50 cycles after each strobe.
  - Expect strobe order bc, home(1000,500), x=9000, y=700, x=1000, y=900, x=9000.
  - Expect scan_done once, with line_idx=2.
- Zero lines: lines=0.
  - Expect bc, home, then scan_done. laser_en never rises.
- Timeout: done_x withheld during line 0 with TIMEOUT=1000.
  - Expect err=1 after 1000 cycles in WAIT_L, laser_en=0, busy=0, no scan_done.
  - A following start clears err.
- Abort during DWELL of line 1.
  - Expect IDLE next cycle, busy=0, line_idx=1 held.
  - Expect no em_new_val_y afterwards.
- Gap and simultaneity:
  - done_x and done_y in the same cycle in WAIT_H: home completes, and the LINE strobe comes exactly GAP+1 cycles later.
  - start with abort in the same cycle: stays IDLE.
- Y wrap: y_start=16'hFF00, pitch=16'h0200, lines=2.
  - Expect em_new_y=16'h0100 at STEP_Y.
